m_seq_chk: RTL and testbench
============================

# m_seq_chk

Receive-side companion to the m-sequence generator: a self-synchronising PRBS checker for the bit stream that comes out of the QAM demodulator/slicer. It acquires the generator's sequence from received bits using the same feedback taps, then free-runs (flywheel) and compares each received bit against the prediction. It reports lock, per-bit errors and saturating bit/error counters for BER measurement, and drops lock when the error density exceeds a threshold.

## Interface
- REG_LEN, 4, LFSR length; supported 2..13, same tap table as the generator
- LOCK_CNT, 16, consecutive correct predictions required to declare lock
- LOSS_ERR, 8, errors within one window that force loss of lock
- LOSS_WIN, 64, window length in valid bits
- CNT_W, 32, width of bit_cnt/err_cnt
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bit_in  in  1  received bit
- bit_valid  in  1  bit_in qualifier; one bit consumed per cycle with bit_valid=1
- clr  in  1  synchronous clear of bit_cnt/err_cnt
- locked  out  1  checker in LOCKED state
- err_pulse  out  1  one-cycle flag: last valid bit mismatched while LOCKED
- err_cnt  out  CNT_W  saturating error count (LOCKED bits only)
- bit_cnt  out  CNT_W  saturating count of bits checked while LOCKED

## Operation
- History register h[REG_LEN-1:0]; h[0] = most recent bit. Each valid bit: h <= {h[REG_LEN-2:0], b}.
- Prediction p = XOR of h at taps: 2:{0,1} 3:{0,2} 4:{0,3} 5:{1,4} 6:{0,5} 7:{2,6} 8:{1,2,3,7} 9:{3,8} 10:{2,9} 11:{1,10} 12:{0,3,5,11} 13:{0,2,3,12}. Unsupported REG_LEN: stays in HUNT forever, locked=0.
- States: HUNT, ACQ, LOCKED. Only valid bits advance anything; bit_valid=0 holds all state, err_pulse=0.
- HUNT: shift bit_in into h, fill counter counts to REG_LEN then holds. Once filled, if the updated h is nonzero -> ACQ with match_cnt=0; all-zero h stays in HUNT (stuck-at-0 line never locks).
- ACQ: compare bit_in vs p; shift bit_in into h. Match -> match_cnt+1; reaching LOCK_CNT -> LOCKED, window counters 0. Mismatch -> match_cnt=0, stay ACQ. Updated h all-zero -> HUNT, fill=0.
- LOCKED: compare bit_in vs p; shift p (not bit_in) into h, so one line error costs exactly one counted error. Every valid bit: bit_cnt+1, win_pos+1. Mismatch: err_pulse=1, err_cnt+1, win_err+1.
- Window: after the LOSS_WIN-th bit, win_pos and win_err reset to 0 (same edge). If win_err reaches LOSS_ERR -> HUNT, fill=0, match_cnt=0; that error still counted.
- Counters saturate at 2^CNT_W-1 (no wrap). clr has priority over increments: counters load 0 on that edge; state machine and err_pulse unaffected.

## Timing
- Reset: state HUNT, h=0, all internal counters 0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0. Reset mid-operation clears outputs immediately (asynchronous).
- All outputs registered; a bit sampled at edge k is reflected in locked/err_pulse/counters after edge k.
- Acquisition latency on a clean stream: REG_LEN + LOCK_CNT valid bits; locked rises on the edge consuming the last of them.
- Loss: locked falls on the edge consuming the LOSS_ERR-th error in a window.
- err_pulse high exactly one cycle per erroneous bit; back-to-back errors give back-to-back pulses.
- Bits consumed in HUNT/ACQ and the lock-acquiring bit are not counted in bit_cnt; bits after entering LOCKED are.

## Test plan
- Generator REG_LEN=4, bit_valid=1 continuous, 1000 bits -> locked rises after 20th bit, stays high; err_cnt=0, bit_cnt=980, err_pulse never set.
- Locked REG_LEN=4, invert one bit -> err_pulse one cycle, err_cnt=1, locked stays 1, no further errors.
- Locked, invert 8 bits within one 64-bit window -> locked falls on the 8th error, err_cnt=8; clean stream resumes -> relock after 20 more bits.
- bit_in stuck at 0 for 200 valid bits -> locked=0, err_cnt=0, bit_cnt=0 throughout; stuck at 1 with REG_LEN=4 -> prediction 0 mismatches, never locks.
- REG_LEN=7, bit_valid asserted every 3rd cycle -> lock after 23 valid bits; counters change only on valid cycles; period-127 stream runs 500 bits error-free.
- Locked, clr coincident with an erroneous bit -> err_cnt=0, bit_cnt=0, err_pulse=1; rst_n pulsed low mid-lock -> locked/err_pulse/counters 0 without a clock edge, reacquire in 20 bits.

Source files
------------

// File: rtl/m_seq_chk.sv
// m_seq_chk: self-synchronising PRBS (m-sequence) checker.
// Acquires the generator sequence from received bits. Once locked it free-runs
// on its own prediction and compares every received bit against it. It reports
// lock, per-bit error pulses and saturating bit/error counters, and drops lock
// when too many errors fall inside one window.
module m_seq_chk #(
    parameter int REG_LEN  = 4,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_ERR = 8,
    parameter int LOSS_WIN = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    // Feedback tap table shared with the generator (bit i set = tap on h[i]).
    function automatic logic [12:0] tap_table(input int n);
        logic [12:0] t;
        case (n)
            2:       t = 13'h0003;
            3:       t = 13'h0005;
            4:       t = 13'h0009;
            5:       t = 13'h0012;
            6:       t = 13'h0021;
            7:       t = 13'h0044;
            8:       t = 13'h008E;
            9:       t = 13'h0108;
            10:      t = 13'h0204;
            11:      t = 13'h0402;
            12:      t = 13'h0829;
            13:      t = 13'h100D;
            default: t = 13'h0000;
        endcase
        return t;
    endfunction

    // Tap mask trimmed to the history register width.
    function automatic logic [REG_LEN-1:0] reg_mask();
        logic [12:0]        full;
        logic [REG_LEN-1:0] m;
        full = tap_table(REG_LEN);
        m    = {REG_LEN{1'b0}};
        for (int i = 0; i < REG_LEN; i++) begin
            m[i] = (i < 13) ? full[i] : 1'b0;
        end
        return m;
    endfunction

    localparam logic [REG_LEN-1:0] TAP_MASK  = reg_mask();
    localparam logic               SUPPORTED = (tap_table(REG_LEN) != 13'h0000);

    // Parity of the tapped history bits gives the next expected bit.
    function automatic logic predict(input logic [REG_LEN-1:0] h);
        return ^(h & TAP_MASK);
    endfunction

    localparam int FILL_W  = $clog2(REG_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WPOS_W  = $clog2(LOSS_WIN + 1);
    localparam int WERR_W  = $clog2(LOSS_ERR + 1);

    localparam logic [REG_LEN-1:0] H_ZERO     = {REG_LEN{1'b0}};
    localparam logic [FILL_W-1:0]  FILL_ZERO  = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1'b1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(REG_LEN);
    localparam logic [MATCH_W-1:0] MATCH_ZERO = {MATCH_W{1'b0}};
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1'b1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WPOS_W-1:0]  WPOS_ZERO  = {WPOS_W{1'b0}};
    localparam logic [WPOS_W-1:0]  WPOS_ONE   = WPOS_W'(1'b1);
    localparam logic [WPOS_W-1:0]  WPOS_LAST  = WPOS_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_ZERO  = {WERR_W{1'b0}};
    localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_ERR);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REG_LEN-1:0] h_q, h_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WPOS_W-1:0]  wpos_q, wpos_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;

    logic               pred_s;
    logic               miss_s;
    logic [REG_LEN-1:0] shift_in_s;
    logic [REG_LEN-1:0] shift_p_s;
    logic [FILL_W-1:0]  fill_inc_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic [WERR_W-1:0]  werr_inc_s;
    logic               bit_inc_s;
    logic               err_inc_s;

    assign pred_s      = predict(h_q);
    assign miss_s      = bit_in ^ pred_s;
    assign shift_in_s  = {h_q[REG_LEN-2:0], bit_in};
    // While locked the prediction, not the line bit, is shifted in, so a line
    // error cannot corrupt later predictions.
    assign shift_p_s   = {h_q[REG_LEN-2:0], pred_s};
    assign fill_inc_s  = (fill_q == FILL_FULL) ? fill_q : (fill_q + FILL_ONE);
    assign match_inc_s = match_q + MATCH_ONE;
    assign werr_inc_s  = werr_q + WERR_W'(miss_s);

    // Next-state logic for HUNT/ACQ/LOCKED, history, fill, match and window counters.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_d      = fill_q;
        match_d     = match_q;
        wpos_d      = wpos_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        bit_inc_s   = 1'b0;
        err_inc_s   = 1'b0;
        if (bit_valid) begin
            case (state_q)
                S_HUNT: begin
                    h_d    = shift_in_s;
                    fill_d = fill_inc_s;
                    // An all-zero history is the LFSR lock-up state; never acquire on it.
                    if (SUPPORTED && (fill_inc_s == FILL_FULL) && (shift_in_s != H_ZERO)) begin
                        state_d = S_ACQ;
                        match_d = MATCH_ZERO;
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                S_ACQ: begin
                    h_d = shift_in_s;
                    if (shift_in_s == H_ZERO) begin
                        state_d = S_HUNT;
                        fill_d  = FILL_ZERO;
                        match_d = MATCH_ZERO;
                    end else if (miss_s) begin
                        match_d = MATCH_ZERO;
                    end else if (match_inc_s == MATCH_LOCK) begin
                        state_d = S_LOCKED;
                        match_d = MATCH_ZERO;
                        wpos_d  = WPOS_ZERO;
                        werr_d  = WERR_ZERO;
                    end else begin
                        match_d = match_inc_s;
                    end
                end
                S_LOCKED: begin
                    h_d         = shift_p_s;
                    bit_inc_s   = 1'b1;
                    err_inc_s   = miss_s;
                    err_pulse_d = miss_s;
                    if (werr_inc_s == WERR_LOSS) begin
                        state_d = S_HUNT;
                        fill_d  = FILL_ZERO;
                        match_d = MATCH_ZERO;
                        wpos_d  = WPOS_ZERO;
                        werr_d  = WERR_ZERO;
                    end else if (wpos_q == WPOS_LAST) begin
                        wpos_d = WPOS_ZERO;
                        werr_d = WERR_ZERO;
                    end else begin
                        wpos_d = wpos_q + WPOS_ONE;
                        werr_d = werr_inc_s;
                    end
                end
                default: begin
                    state_d = S_HUNT;
                    fill_d  = FILL_ZERO;
                    match_d = MATCH_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Saturating result counters; clr wins over any increment on the same edge.
    always_comb begin
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        locked_d  = (state_d == S_LOCKED);
        if (clr) begin
            err_cnt_d = CNT_ZERO;
            bit_cnt_d = CNT_ZERO;
        end else begin
            if (err_inc_s && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (bit_inc_s && (bit_cnt_q != CNT_MAX)) begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end
    end

    // State, history, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            h_q         <= H_ZERO;
            fill_q      <= FILL_ZERO;
            match_q     <= MATCH_ZERO;
            wpos_q      <= WPOS_ZERO;
            werr_q      <= WERR_ZERO;
            err_cnt_q   <= CNT_ZERO;
            bit_cnt_q   <= CNT_ZERO;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            wpos_q      <= wpos_d;
            werr_q      <= werr_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_m_seq_chk.sv
// Directed bench for m_seq_chk: a REG_LEN=4 checker (plus a 4-bit-counter
// copy sharing its inputs for saturation) driven by a step table, hand
// sequences for clr/reset corners, and a REG_LEN=7 checker with sparse valid.
module tb_m_seq_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b4 = 1'b0, bv4 = 1'b0, clr4 = 1'b0;
    logic        b7 = 1'b0, bv7 = 1'b0;
    logic        l4, p4, l4s, p4s, l7, p7;
    logic [31:0] e4, c4, e7, c7;
    logic [3:0]  e4s, c4s;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses7 = 0;
    int hold_viol = 0;
    logic [3:0] g4 = 4'b1001;
    logic [6:0] g7 = 7'b0000001;

    always #5 clk = ~clk;

    m_seq_chk #(.REG_LEN(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bit_in(b4), .bit_valid(bv4), .clr(clr4),
        .locked(l4), .err_pulse(p4), .err_cnt(e4), .bit_cnt(c4));

    m_seq_chk #(.REG_LEN(4), .CNT_W(4)) u4s (
        .clk(clk), .rst_n(rst_n), .bit_in(b4), .bit_valid(bv4), .clr(clr4),
        .locked(l4s), .err_pulse(p4s), .err_cnt(e4s), .bit_cnt(c4s));

    m_seq_chk #(.REG_LEN(7)) u7 (
        .clk(clk), .rst_n(rst_n), .bit_in(b7), .bit_valid(bv7), .clr(1'b0),
        .locked(l7), .err_pulse(p7), .err_cnt(e7), .bit_cnt(c7));

    typedef struct {
        bit do_rst;
        int n;
        int n_inv;
        int stuck;   // 0 generator, 1 stuck-at-0, 2 stuck-at-1
        bit exp_l;
        int exp_e;
        int exp_b;
        int exp_p;
    } step_t;

    localparam int NSTEP = 13;
    step_t tbl[NSTEP];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bv4 = 1'b0; bv7 = 1'b0; clr4 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send4(input logic inv, input int stuck, input logic c);
        logic tb;
        if (stuck == 1) begin
            tb = 1'b0;
        end else if (stuck == 2) begin
            tb = 1'b1;
        end else begin
            tb = g4[0] ^ g4[3];
            g4 = {g4[2:0], tb};
            tb = tb ^ inv;
        end
        @(negedge clk);
        b4 = tb; bv4 = 1'b1; clr4 = c;
        @(posedge clk);
        #1;
        if (p4) pulses++;
    endtask

    task automatic send7();
        logic tb;
        logic [31:0] sc, se;
        logic sl;
        tb = g7[2] ^ g7[6];
        g7 = {g7[5:0], tb};
        @(negedge clk);
        b7 = tb; bv7 = 1'b1;
        @(posedge clk);
        #1;
        if (p7) pulses7++;
        sc = c7; se = e7; sl = l7;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bv7 = 1'b0; b7 = ~b7;
            @(posedge clk);
            #1;
            if (c7 != sc || e7 != se || l7 != sl || p7) hold_viol++;
        end
    endtask

    initial begin
        //            rst  n    inv stk  l  err   bits  pulses
        tbl[0]  = '{1'b0, 19,   0, 0, 1'b0,  0,    0, 0};
        tbl[1]  = '{1'b0, 1,    0, 0, 1'b1,  0,    0, 0};
        tbl[2]  = '{1'b0, 980,  0, 0, 1'b1,  0,  980, 0};
        tbl[3]  = '{1'b0, 1,    1, 0, 1'b1,  1,  981, 1};
        tbl[4]  = '{1'b0, 50,   0, 0, 1'b1,  1, 1031, 0};
        tbl[5]  = '{1'b0, 7,    7, 0, 1'b1,  8, 1038, 7};
        tbl[6]  = '{1'b0, 50,   0, 0, 1'b1,  8, 1088, 0};
        tbl[7]  = '{1'b0, 7,    7, 0, 1'b1, 15, 1095, 7};
        tbl[8]  = '{1'b0, 1,    1, 0, 1'b0, 16, 1096, 1};
        tbl[9]  = '{1'b0, 19,   0, 0, 1'b0, 16, 1096, 0};
        tbl[10] = '{1'b0, 1,    0, 0, 1'b1, 16, 1096, 0};
        tbl[11] = '{1'b1, 200,  0, 1, 1'b0,  0,    0, 0};
        tbl[12] = '{1'b1, 200,  0, 2, 1'b0,  0,    0, 0};

        // Reset state before any clock edge.
        #2;
        chk("reset locked", l4, 0);
        chk("reset err_pulse", p4, 0);
        chk("reset err_cnt", e4, 0);
        chk("reset bit_cnt", c4, 0);
        do_reset();

        for (int s = 0; s < NSTEP; s++) begin
            if (tbl[s].do_rst) do_reset();
            pulses = 0;
            for (int k = 0; k < tbl[s].n; k++) begin
                send4(k < tbl[s].n_inv, tbl[s].stuck, 1'b0);
            end
            chk($sformatf("step%0d locked", s), l4, tbl[s].exp_l);
            chk($sformatf("step%0d err_cnt", s), e4, tbl[s].exp_e);
            chk($sformatf("step%0d bit_cnt", s), c4, tbl[s].exp_b);
            chk($sformatf("step%0d pulses", s), pulses, tbl[s].exp_p);
            chk($sformatf("step%0d sat err_cnt", s), e4s, sat15(tbl[s].exp_e));
            chk($sformatf("step%0d sat bit_cnt", s), c4s, sat15(tbl[s].exp_b));
        end

        // Fresh lock: locked rises exactly on the 20th bit.
        do_reset();
        for (int k = 0; k < 19; k++) send4(1'b0, 0, 1'b0);
        chk("hs lock 19", l4, 0);
        send4(1'b0, 0, 1'b0);
        chk("hs lock 20", l4, 1);
        chk("hs lock bit_cnt", c4, 0);

        // clr coincident with an erroneous bit.
        send4(1'b1, 0, 1'b1);
        chk("clr err_pulse", p4, 1);
        chk("clr err_cnt", e4, 0);
        chk("clr bit_cnt", c4, 0);
        chk("clr locked", l4, 1);
        send4(1'b0, 0, 1'b0);
        chk("post clr err_pulse", p4, 0);
        chk("post clr err_cnt", e4, 0);
        chk("post clr bit_cnt", c4, 1);

        // Asynchronous reset mid-lock with err_pulse high.
        send4(1'b1, 0, 1'b0);
        chk("pre rst err_pulse", p4, 1);
        chk("pre rst err_cnt", e4, 1);
        chk("pre rst bit_cnt", c4, 2);
        bv4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst locked", l4, 0);
        chk("async rst err_pulse", p4, 0);
        chk("async rst err_cnt", e4, 0);
        chk("async rst bit_cnt", c4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 19; k++) send4(1'b0, 0, 1'b0);
        chk("relock 19", l4, 0);
        send4(1'b0, 0, 1'b0);
        chk("relock 20", l4, 1);
        chk("relock err_cnt", e4, 0);
        chk("relock bit_cnt", c4, 0);

        // REG_LEN=7, one valid bit every third cycle.
        do_reset();
        for (int k = 0; k < 22; k++) send7();
        chk("r7 lock 22", l7, 0);
        send7();
        chk("r7 lock 23", l7, 1);
        for (int k = 0; k < 500; k++) send7();
        chk("r7 locked", l7, 1);
        chk("r7 err_cnt", e7, 0);
        chk("r7 bit_cnt", c7, 500);
        chk("r7 pulses", pulses7, 0);
        chk("r7 idle hold", hold_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
